// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame controller and its position counter.
package sobel_pkg;

    localparam int COL_W = 11;   // column counter width, saturates at 2047
    localparam int ROW_W = 10;   // row counter width, saturates at 1023
    localparam int CNT_W = 19;   // edge pixel counter width
    localparam int TH_W  = 11;   // Sobel threshold width

    // Frame controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sobel_pos_counter.sv
// Pixel/line position tracker for a href/clken video stream.
// Counts columns per accepted pixel and rows per href falling edge, flags
// lines whose length differs from IMG_W and reports whether the current
// position lies in the border band. Positions are pre-increment, i.e. the
// position of the pixel presented on this cycle.
module sobel_pos_counter
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int BORDER = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             count_en,
    input  logic             href,
    input  logic             clken,
    output logic [ROW_W-1:0] row,
    output logic             line_err,
    output logic             border
);

    localparam logic [COL_W-1:0] COL_LO  = COL_W'(BORDER);
    localparam logic [COL_W-1:0] COL_HI  = COL_W'(IMG_W - BORDER);
    localparam logic [ROW_W-1:0] ROW_LO  = ROW_W'(BORDER);
    localparam logic [ROW_W-1:0] ROW_HI  = ROW_W'(IMG_H - BORDER);
    localparam logic [COL_W-1:0] COL_EXP = COL_W'(IMG_W);
    localparam bit               MASK_ON = (BORDER > 0);

    logic [COL_W-1:0] col;
    logic             href_q;
    logic             accept;
    logic             line_end;

    assign accept   = href & clken;
    assign line_end = href_q & ~href;
    assign line_err = count_en & line_end & (col != COL_EXP);
    assign border   = MASK_ON &&
                      ((col < COL_LO) || (col >= COL_HI) ||
                       (row < ROW_LO) || (row >= ROW_HI));

    // Track href history and advance col/row, both saturating
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            href_q <= 1'b0;
            col    <= '0;
            row    <= '0;
        end else begin
            href_q <= href;
            if (clear) begin
                col <= '0;
                row <= '0;
            end else if (count_en) begin
                if (line_end) begin
                    col <= '0;
                    if (row != '1) begin
                        row <= row + ROW_W'(1);
                    end
                end else if (accept && (col != '1)) begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame-level controller behind the Sobel edge detector.
// Applies threshold updates only at frame boundaries, masks border pixels,
// counts edge pixels per frame and flags frames with the wrong geometry.
//
// Stream handshake: a pixel is transferred when in_href and in_clken are
// both high; there is no back-pressure, the stream is re-timed by exactly
// one cycle onto out_* and out_bit is forced low whenever out_href is low.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int TH_DEFAULT = 250,
    parameter int BORDER     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [TH_W-1:0]  cfg_threshold,
    input  logic             cfg_wr,
    output logic [TH_W-1:0]  sobel_threshold,
    input  logic             in_vsync,
    input  logic             in_href,
    input  logic             in_clken,
    input  logic             in_bit,
    output logic             out_vsync,
    output logic             out_href,
    output logic             out_clken,
    output logic             out_bit,
    output logic             frame_done,
    output logic [CNT_W-1:0] edge_count,
    output logic             frame_err,
    output logic             busy
);

    localparam logic [TH_W-1:0]  TH_RST  = TH_W'(TH_DEFAULT);
    localparam logic [ROW_W-1:0] ROW_EXP = ROW_W'(IMG_H);

    state_t           state;
    logic [TH_W-1:0]  shadow;
    logic             pending;
    logic             vs_q;
    logic             vs_rise;
    logic             commit;
    logic [CNT_W-1:0] edge_acc;
    logic             err_acc;
    logic             active;
    logic             mask_now;
    logic             count_edge;
    logic [ROW_W-1:0] row;
    logic             line_err;
    logic             border;

    assign vs_rise    = in_vsync & ~vs_q;
    assign commit     = vs_rise & pending;
    // Position only means something while a frame is being tracked
    assign active     = (state == ST_ACTIVE) & en;
    assign mask_now   = active & border;
    assign count_edge = active & in_href & in_clken & ~border & ~in_bit;

    sobel_pos_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .BORDER (BORDER)
    ) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == ST_SYNC),
        .count_en (active),
        .href     (in_href),
        .clken    (in_clken),
        .row      (row),
        .line_err (line_err),
        .border   (border)
    );

    // Re-time the stream by one cycle, applying the border mask
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q      <= 1'b0;
            out_vsync <= 1'b0;
            out_href  <= 1'b0;
            out_clken <= 1'b0;
            out_bit   <= 1'b0;
        end else begin
            vs_q      <= in_vsync;
            out_vsync <= in_vsync;
            out_href  <= in_href;
            out_clken <= in_clken;
            out_bit   <= in_href & (in_bit | mask_now);
        end
    end

    // Shadow/active threshold pair; a write landing on a commit edge waits
    // for the following commit because pending is re-armed by the write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow          <= TH_RST;
            sobel_threshold <= TH_RST;
            pending         <= 1'b0;
        end else begin
            if (cfg_wr) begin
                shadow <= cfg_threshold;
            end
            if (commit) begin
                sobel_threshold <= shadow;
            end
            if (cfg_wr) begin
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    // Frame FSM with registered frame_done/edge_count/frame_err/busy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            edge_count <= '0;
            frame_err  <= 1'b0;
            edge_acc   <= '0;
            err_acc    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (en && vs_rise) begin
                        state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    edge_acc <= '0;
                    err_acc  <= 1'b0;
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (!in_vsync) begin
                        state <= ST_ACTIVE;
                        busy  <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!en) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (vs_rise) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        edge_count <= edge_acc;
                        frame_err  <= err_acc | line_err | (row != ROW_EXP);
                    end else begin
                        if (count_edge) begin
                            edge_acc <= sat_inc_cnt(edge_acc);
                        end
                        if (line_err) begin
                            err_acc <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= en ? ST_SYNC : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Testbench for sobel_frame_ctrl on a reduced 16x8 geometry.
`timescale 1ns/1ps
module tb_sobel_frame_ctrl;
    import sobel_pkg::*;

    localparam int W      = 16;
    localparam int H      = 8;
    localparam int TH_DEF = 250;
    localparam int BRD    = 1;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [TH_W-1:0]  cfg_threshold = '0;
    logic             cfg_wr = 1'b0;
    logic [TH_W-1:0]  sobel_threshold;
    logic             in_vsync = 1'b0;
    logic             in_href = 1'b0;
    logic             in_clken = 1'b0;
    logic             in_bit = 1'b1;
    logic             out_vsync;
    logic             out_href;
    logic             out_clken;
    logic             out_bit;
    logic             frame_done;
    logic [CNT_W-1:0] edge_count;
    logic             frame_err;
    logic             busy;

    always #5 clk = ~clk;

    sobel_frame_ctrl #(
        .IMG_W      (W),
        .IMG_H      (H),
        .TH_DEFAULT (TH_DEF),
        .BORDER     (BRD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .cfg_threshold   (cfg_threshold),
        .cfg_wr          (cfg_wr),
        .sobel_threshold (sobel_threshold),
        .in_vsync        (in_vsync),
        .in_href         (in_href),
        .in_clken        (in_clken),
        .in_bit          (in_bit),
        .out_vsync       (out_vsync),
        .out_href        (out_href),
        .out_clken       (out_clken),
        .out_bit         (out_bit),
        .frame_done      (frame_done),
        .edge_count      (edge_count),
        .frame_err       (frame_err),
        .busy            (busy)
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  exp_q[$];   // {vsync, href, clken, bit} expected one cycle later
    logic [19:0] frm_q[$];   // {frame_err, edge_count} expected at frame_done
    logic [3:0]  mon_e;
    logic [19:0] mon_f;
    logic        rst_v = 1'b0;
    logic        en_v  = 1'b1;
    logic        trk   = 1'b0; // DUT is tracking the current frame

    typedef struct packed {
        int   pat;
        int   rows;
        int   sr;      // row driven one pixel short, -1 for none
        int   cfg;     // threshold written during row 1, -1 for none
        int   th;      // threshold expected while the frame runs
        int   edges;
        logic err;
    } frame_vec_t;

    frame_vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic bdr(input int c, input int r);
        return (c < BRD) || (c >= W - BRD) || (r < BRD) || (r >= H - BRD);
    endfunction

    function automatic logic pix(input int p, input int c, input int r);
        case (p)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return ((c + r) % 2) != 0;
            default: return ((c * 3 + r) % 5) != 0;
        endcase
    endfunction

    function automatic int exp_edges(input int p, input int rows, input int sr);
        int n = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < ((r == sr) ? W - 1 : W); c++) begin
                if (!bdr(c, r) && (pix(p, c, r) == 1'b0)) n++;
            end
        end
        return n;
    endfunction

    function automatic frame_vec_t mk(input int p, input int rows, input int sr,
                                      input int cfg, input int th);
        frame_vec_t v;
        v.pat   = p;
        v.rows  = rows;
        v.sr    = sr;
        v.cfg   = cfg;
        v.th    = th;
        v.edges = exp_edges(p, rows, sr);
        v.err   = (rows != H) || (sr >= 0);
        return v;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (exp_q.size() >= 2) begin
            mon_e = exp_q.pop_front();
            check("stream", {28'd0, out_vsync, out_href, out_clken, out_bit}, {28'd0, mon_e});
        end
    end

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            if (frm_q.size() == 0) begin
                check("unexpected_frame_done", {31'd0, frame_done}, 32'd0);
            end else begin
                mon_f = frm_q.pop_front();
                check("edge_count", {13'd0, edge_count}, {13'd0, mon_f[18:0]});
                check("frame_err", {31'd0, frame_err}, {31'd0, mon_f[19]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input logic vs, input logic hr, input logic ck, input logic b,
                               input int c, input int r,
                               input logic wr = 1'b0, input logic [TH_W-1:0] th = '0);
        logic m;
        @(posedge clk);
        #1;
        rst_n         = rst_v;
        en            = en_v;
        in_vsync      = vs;
        in_href       = hr;
        in_clken      = ck;
        in_bit        = b;
        cfg_wr        = wr;
        cfg_threshold = th;
        m = trk && en_v && bdr(c, r);
        if (!rst_v) exp_q.push_back(4'b0000);
        else        exp_q.push_back({vs, hr, ck, hr & (b | m)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    endtask

    task automatic drive_line(input int r, input int len, input int p,
                              input int wr_at, input logic [TH_W-1:0] th);
        for (int c = 0; c < len; c++) begin
            if ($urandom_range(0, 7) == 0)
                drive_cycle(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), c, r);
            drive_cycle(1'b0, 1'b1, 1'b1, pix(p, c, r), c, r, (c == wr_at), th);
        end
        idle(3);
    endtask

    task automatic vsync_pulse();
        idle(1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
        idle(3);
    endtask

    task automatic run_body(input frame_vec_t v);
        for (int r = 0; r < v.rows; r++) begin
            if (r == v.rows / 2) begin
                check("threshold_mid", {21'd0, sobel_threshold}, 32'(v.th));
                check("busy_active", {31'd0, busy}, 32'd1);
            end
            drive_line(r, (r == v.sr) ? W - 1 : W, v.pat,
                       (r == 1 && v.cfg >= 0) ? 5 : -1, TH_W'(v.cfg));
        end
        check("threshold_end", {21'd0, sobel_threshold}, 32'(v.th));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        tbl[0] = mk(0, H,     -1,  -1, 250);
        tbl[1] = mk(1, H,     -1, 300, 250);
        tbl[2] = mk(2, H,      3,  -1, 300);
        tbl[3] = mk(1, H,     -1,  -1, 300);
        tbl[4] = mk(3, H - 1, -1, 400, 300);
        tbl[5] = mk(2, H + 1, -1,  -1, 400);
        tbl[6] = mk(1, H,     -1,  -1, 400);

        // reset state
        rst_v = 1'b0;
        idle(3);
        rst_v = 1'b1;
        idle(1);
        check("rst_threshold", {21'd0, sobel_threshold}, 32'(TH_DEF));
        check("rst_edge_count", {13'd0, edge_count}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);

        // table-driven frames, each closed by the next vsync
        vsync_pulse();
        trk = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_body(tbl[i]);
            frm_q.push_back({tbl[i].err, 19'(tbl[i].edges)});
            vsync_pulse();
        end

        // en dropped mid-frame: no frame_done, results of frame 6 held
        for (int r = 0; r < H / 2; r++) drive_line(r, W, 1, -1, '0);
        en_v = 1'b0;
        drive_line(H / 2, W, 1, -1, '0);
        check("busy_after_en_drop", {31'd0, busy}, 32'd0);
        for (int r = H / 2 + 1; r < H; r++) drive_line(r, W, 2, -1, '0);
        vsync_pulse();
        check("edge_count_held", {13'd0, edge_count}, 32'(tbl[6].edges));
        check("frame_err_held", {31'd0, frame_err}, {31'd0, tbl[6].err});
        en_v = 1'b1;
        vsync_pulse();

        // cfg_wr on the commit edge: old shadow commits, new value waits
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 11'd500);
        idle(1);
        frm_q.push_back({1'b1, 19'd0});
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 11'd600);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
        check("th_same_edge", {21'd0, sobel_threshold}, 32'd500);
        idle(4);
        check("th_hold_after_edge", {21'd0, sobel_threshold}, 32'd500);
        frm_q.push_back({1'b1, 19'd0});
        vsync_pulse();
        check("th_late_commit", {21'd0, sobel_threshold}, 32'd600);

        // reset pulse mid-frame with a write still pending
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 11'd700);
        drive_line(0, W, 1, -1, '0);
        drive_line(1, W, 1, -1, '0);
        for (int c = 0; c < 5; c++) drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, c, 2);
        rst_v = 1'b0;
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 5, 2);
        rst_v = 1'b1;
        trk   = 1'b0;
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 6, 2);
        check("rst_mid_out_href", {31'd0, out_href}, 32'd0);
        check("rst_mid_out_bit", {31'd0, out_bit}, 32'd0);
        check("rst_mid_threshold", {21'd0, sobel_threshold}, 32'(TH_DEF));
        check("rst_mid_edge_count", {13'd0, edge_count}, 32'd0);
        check("rst_mid_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        for (int c = 7; c < W; c++) drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, c, 2);
        idle(3);
        drive_line(3, W, 1, -1, '0);
        vsync_pulse();
        check("th_after_rst_frame", {21'd0, sobel_threshold}, 32'(TH_DEF));
        trk = 1'b1;
        begin
            frame_vec_t v;
            v = mk(1, H, -1, -1, TH_DEF);
            run_body(v);
            frm_q.push_back({v.err, 19'(v.edges)});
        end
        vsync_pulse();
        idle(4);
        check("frames_outstanding", frm_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
